// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose: small program memory that feeds simple_cpu one instruction at a
// time. Every word stays on `instruction` for HOLD_CYCLES rising edges so the
// multi-cycle CPU can finish it. After that the PC advances. A run starts
// from address 0 on `start`. It ends at an end-of-program word (opcode class
// 00), at the last address, or on `abort`.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active low
//   load_en      program write strobe (accepted only while idle)
//   load_addr    program write address
//   load_data    program write data
//   start        launch the program from address 0 (accepted only while idle)
//   abort        stop a running program, no done pulse
//   instruction  registered word to the CPU, zero when not issuing
//   new_instr    one-cycle strobe, first cycle of each new word
//   pc           address of the word currently on `instruction`
//   busy         high while issuing
//   done         one-cycle pulse on normal program end
//   dbg_state    current FSM state (0 idle, 1 issue, 2 done)
//
// Interface semantics: there is no back-pressure. `new_instr` is a pure
// strobe. It marks the first of HOLD_CYCLES cycles in which `instruction`
// and `pc` are valid and stable. The consumer must accept at that rate.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [PC_BITS-1:0]     load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   start,
  input  logic                   abort,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   new_instr,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             dbg_state
);

  localparam int         DEPTH    = 1 << PC_BITS;
  localparam logic [3:0] CNT_INIT = 4'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [INSTR_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [INSTR_WIDTH-1:0] w_instr_nxt;
  logic                   r_new;
  logic                   w_new_nxt;
  logic [PC_BITS-1:0]     r_pc;
  logic [PC_BITS-1:0]     w_pc_nxt;
  logic [3:0]             r_cnt;
  logic [3:0]             w_cnt_nxt;

  logic [PC_BITS-1:0]     w_pc_inc;
  logic [INSTR_WIDTH-1:0] w_word0;
  logic [INSTR_WIDTH-1:0] w_word_next;
  logic                   w_word0_end;
  logic                   w_next_end;
  logic                   w_pc_last;

  assign w_pc_inc    = r_pc + PC_BITS'(1);
  assign w_word0     = r_mem[0];
  assign w_word_next = r_mem[w_pc_inc];
  assign w_word0_end = (w_word0[INSTR_WIDTH-1 -: 2] == 2'b00);
  assign w_next_end  = (w_word_next[INSTR_WIDTH-1 -: 2] == 2'b00);
  // w_pc_inc wraps to 0 at the top address. w_pc_last is tested first,
  // so the wrapped read never issues.
  assign w_pc_last   = (r_pc == {PC_BITS{1'b1}});

  // Writes are accepted only while idle. This keeps a running program
  // intact. Reset also blocks them.
  always_ff @(posedge clk) begin
    if (rst && load_en && (r_state == S_IDLE)) begin
      r_mem[load_addr] <= load_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_instr_nxt = r_instr;
    w_new_nxt   = 1'b0;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        // A load has priority, so start counts only without load_en.
        if (start && !load_en) begin
          w_pc_nxt = '0;
          if (w_word0_end) begin
            w_state_nxt = S_DONE;
            w_instr_nxt = '0;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_ISSUE;
            w_instr_nxt = w_word0;
            w_new_nxt   = 1'b1;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_ISSUE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_instr_nxt = '0;
          w_pc_nxt    = '0;
          w_cnt_nxt   = '0;
        end else if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else if (w_pc_last || w_next_end) begin
          // pc keeps the last issued address through the done cycle.
          w_state_nxt = S_DONE;
          w_instr_nxt = '0;
        end else begin
          w_pc_nxt    = w_pc_inc;
          w_instr_nxt = w_word_next;
          w_new_nxt   = 1'b1;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_pc_nxt    = '0;
        w_instr_nxt = '0;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_instr_nxt = '0;
        w_pc_nxt    = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_instr <= '0;
      r_new   <= 1'b0;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_instr <= w_instr_nxt;
      r_new   <= w_new_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign instruction = r_instr;
  assign new_instr   = r_new;
  assign pc          = r_pc;
  assign busy        = (r_state == S_ISSUE);
  assign done        = (r_state == S_DONE);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int H = 4;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic [4:0]  load_addr;
  logic [19:0] load_data;
  logic        start;
  logic        abort;
  logic [19:0] instruction;
  logic        new_instr;
  logic [4:0]  pc;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // Reference picture of the program memory.
  logic [19:0] mdl_mem [0:31];

  instr_fetch_unit #(
    .INSTR_WIDTH(20),
    .PC_BITS(5),
    .HOLD_CYCLES(H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load_en(load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .start(start),
    .abort(abort),
    .instruction(instruction),
    .new_instr(new_instr),
    .pc(pc),
    .busy(busy),
    .done(done),
    .dbg_state(dbg_state)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [4:0] a, input logic [19:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_en   = 1'b0;
    mdl_mem[a] = d;
  endtask

  // Count of leading words that are not end markers. This is the number of
  // words a run will issue.
  function automatic int prog_len();
    for (int i = 0; i < 32; i++) begin
      if (mdl_mem[i][19:18] == 2'b00) return i;
    end
    return 32;
  endfunction

  // Start a run and check every cycle until the unit is idle again.
  // Cycle k = 0 is the state just after the edge that samples start.
  // Word w is expected for k in [w*H, w*H+H). The done cycle comes at k = n*H.
  // noise: random load_en/start during the run, which must have no effect.
  // abort_at >= 0: raise abort after checking cycle abort_at.
  task automatic run_program(input string tag, input bit noise,
                             input bit abort_on_start, input int abort_at);
    int n;
    logic [19:0] e_instr;
    logic [4:0]  e_pc;
    logic        e_new, e_busy, e_done;
    logic [27:0] exp_v, act_v;
    n = prog_len();
    start = 1'b1;
    abort = abort_on_start;
    step();
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k <= n * H; k++) begin
      if (k < n * H) begin
        e_instr = mdl_mem[k / H];
        e_pc    = 5'(k / H);
        e_new   = (k % H == 0);
        e_busy  = 1'b1;
        e_done  = 1'b0;
      end else begin
        e_instr = '0;
        e_pc    = (n == 0) ? 5'd0 : 5'(n - 1);
        e_new   = 1'b0;
        e_busy  = 1'b0;
        e_done  = 1'b1;
      end
      exp_v = {e_instr, e_pc, e_new, e_busy, e_done};
      act_v = {instruction, pc, new_instr, busy, done};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL %s k=%0d got instr=%h pc=%0d new=%b busy=%b done=%b want instr=%h pc=%0d new=%b busy=%b done=%b",
                 tag, k, instruction, pc, new_instr, busy, done,
                 e_instr, e_pc, e_new, e_busy, e_done);
      end
      if (k == abort_at) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++;
        if ({instruction, pc, new_instr, busy, done} !== 28'd0) begin
          bad++;
          $display("FAIL %s_abort got instr=%h pc=%0d new=%b busy=%b done=%b want all zero",
                   tag, instruction, pc, new_instr, busy, done);
        end
        for (int j = 0; j < 3; j++) begin
          step();
          total++;
          if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_post_abort j=%0d got done=%b busy=%b want 0 0", tag, j, done, busy);
          end
        end
        return;
      end
      if (noise) begin
        load_en   = 1'($urandom_range(0, 1));
        load_addr = 5'($urandom);
        load_data = 20'($urandom);
        start     = 1'($urandom_range(0, 1));
      end
      step();
    end
    load_en = 1'b0;
    start   = 1'b0;
    total++;
    if ({instruction, pc, new_instr, busy, done} !== 28'd0) begin
      bad++;
      $display("FAIL %s_idle got instr=%h pc=%0d new=%b busy=%b done=%b want all zero",
               tag, instruction, pc, new_instr, busy, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; abort = 1'b0;
    step(); step();
    rst = 1'b1;
    total++;
    if ({instruction, pc, new_instr, busy, done} !== 28'd0) begin
      bad++;
      $display("FAIL reset_out got instr=%h pc=%0d new=%b busy=%b done=%b want all zero",
               instruction, pc, new_instr, busy, done);
    end
    for (int i = 0; i < 32; i++) load_word(5'(i), 20'd0);
    load_word(5'd0, 20'h4A5C3);
    load_word(5'd1, 20'h00000);
    // Reset must win over a simultaneous load and start.
    rst = 1'b0; load_en = 1'b1; load_addr = 5'd0; load_data = 20'h00000; start = 1'b1;
    step(); step();
    rst = 1'b1; load_en = 1'b0; start = 1'b0;
    total++;
    if ({instruction, pc, new_instr, busy, done} !== 28'd0) begin
      bad++;
      $display("FAIL reset_again got instr=%h pc=%0d busy=%b done=%b want all zero",
               instruction, pc, busy, done);
    end
    run_program("reset_keep_mem", 1'b0, 1'b0, -1);
  endtask

  task automatic test_normal();
    load_word(5'd0, 20'b01000111000000000000);
    load_word(5'd1, 20'b01010011000000000000);
    load_word(5'd2, 20'b01110010000000000001);
    load_word(5'd3, 20'b00000000000000000000);
    run_program("normal", 1'b0, 1'b0, -1);
  endtask

  task automatic test_halt();
    load_word(5'd0, 20'h00000);
    run_program("halt", 1'b0, 1'b0, -1);
  endtask

  task automatic test_abort();
    load_word(5'd0, 20'b01000111000000000000);
    load_word(5'd1, 20'b01010011000000000000);
    load_word(5'd2, 20'b01110010000000000001);
    load_word(5'd3, 20'b00000000000000000000);
    run_program("abort", 1'b0, 1'b0, H + 1);
    run_program("rerun", 1'b0, 1'b0, -1);
  endtask

  task automatic test_priority();
    load_word(5'd1, 20'h00000);
    // A load with start in the same cycle: the write happens and start is ignored.
    load_en = 1'b1; load_addr = 5'd0; load_data = 20'h4ABCD; start = 1'b1;
    step();
    load_en = 1'b0; start = 1'b0;
    mdl_mem[0] = 20'h4ABCD;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL load_beats_start got busy=%b done=%b want 0 0", busy, done);
    end
    run_program("after_load_start", 1'b0, 1'b0, -1);
    // Writes during a run are blocked. The second run proves the memory is unchanged.
    load_word(5'd1, 20'h8F00F);
    load_word(5'd2, 20'hC0101);
    load_word(5'd3, 20'h00000);
    run_program("load_in_issue", 1'b1, 1'b0, -1);
    run_program("readback", 1'b0, 1'b1, -1);
  endtask

  task automatic test_end_of_memory();
    for (int i = 0; i < 32; i++) load_word(5'(i), 20'b11011000000011110000);
    run_program("end_of_mem", 1'b0, 1'b0, -1);
  endtask

  task automatic test_mid_reset();
    load_word(5'd0, 20'h5_1234);
    load_word(5'd1, 20'h9_8765);
    load_word(5'd2, 20'h0_0000);
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    rst = 1'b0; abort = 1'b1; start = 1'b1; load_en = 1'b1;
    load_addr = 5'd1; load_data = 20'h0_0000;
    step();
    rst = 1'b1; abort = 1'b0; start = 1'b0; load_en = 1'b0;
    total++;
    if ({instruction, pc, new_instr, busy, done} !== 28'd0) begin
      bad++;
      $display("FAIL mid_reset got instr=%h pc=%0d new=%b busy=%b done=%b want all zero",
               instruction, pc, new_instr, busy, done);
    end
    run_program("after_mid_reset", 1'b0, 1'b0, -1);
  endtask

  task automatic test_random();
    int len;
    logic [19:0] w;
    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(0, 31);
      for (int i = 0; i < 32; i++) begin
        w = 20'($urandom);
        if (i == len) w[19:18] = 2'b00;
        else w[19:18] = 2'($urandom_range(1, 3));
        load_word(5'(i), w);
      end
      if (r == 3) run_program("random_abort", 1'b1, 1'b0, (len == 0) ? -1 : $urandom_range(0, len * H - 1));
      else run_program("random", 1'b1, 1'($urandom_range(0, 1)), -1);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_halt();
    test_abort();
    test_priority();
    test_end_of_memory();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
